// File: rtl/stream_ctrl_mch.sv
// Frame-aligned stream gate: opens/closes the multi-channel pixel stream only on whole-frame boundaries.
// Two-clock latency, no back-pressure; supports continuous and N-shot acquisition with a passed-frame counter.
module stream_ctrl_mch #(
  parameter int DATA_WIDTH  = 10,
  parameter int CHANNEL_NUM = 1,
  parameter int REG_WD      = 32
) (
  input  logic                              clk_sensor_pix,
  input  logic                              reset_sensor,
  input  logic                              i_fval,
  input  logic                              i_lval,
  input  logic [DATA_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
  input  logic                              i_stream_enable,
  input  logic                              i_acquisition_start,
  input  logic                              i_encrypt_state,
  input  logic [REG_WD-1:0]                 iv_frame_num,
  output logic                              o_fval,
  output logic                              o_lval,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic                              o_full_frame_state,
  output logic                              o_frame_done,
  output logic [REG_WD-1:0]                 ov_frame_cnt
);

  localparam int                PW    = DATA_WIDTH * CHANNEL_NUM;
  localparam logic [REG_WD-1:0] L_ONE = REG_WD'(1);

  typedef enum logic [1:0] {IDLE, PASS, SKIP} state_t;

  state_t            r_state;
  logic              r_fval_d;
  logic              r_lval_d;
  logic [PW-1:0]     r_data_d;
  logic              r_se_d;
  logic              r_continuous;
  logic [REG_WD-1:0] r_frames_left;
  logic              r_done_pend;

  logic w_enable;
  logic w_rise;
  logic w_fall;
  logic w_se_rise;
  logic w_in_pass;
  logic w_pass_ok;

  assign w_enable  = i_stream_enable & i_acquisition_start & i_encrypt_state;
  assign w_rise    = i_fval & ~r_fval_d;
  assign w_fall    = ~i_fval & r_fval_d;
  assign w_se_rise = i_stream_enable & ~r_se_d;
  assign w_in_pass = (r_state == PASS);
  assign w_pass_ok = w_enable & (r_continuous | (r_frames_left != '0));

  // fval_d resets high so a frame already in progress at reset release never looks like a rise.
  always_ff @(posedge clk_sensor_pix) begin
    if (reset_sensor) begin
      r_fval_d <= 1'b1;
      r_lval_d <= 1'b0;
      r_data_d <= '0;
    end else begin
      r_fval_d <= i_fval;
      r_lval_d <= i_lval;
      r_data_d <= iv_pix_data;
    end
  end

  // Frame budget: a zero load means continuous; a counted run that reaches zero stays exhausted.
  always_ff @(posedge clk_sensor_pix) begin
    if (reset_sensor) begin
      r_se_d        <= 1'b0;
      r_frames_left <= '0;
      r_continuous  <= 1'b1;
    end else begin
      r_se_d <= i_stream_enable;
      if (w_se_rise) begin
        r_frames_left <= iv_frame_num;
        r_continuous  <= (iv_frame_num == '0);
      end else if (w_in_pass && w_fall && !r_continuous && (r_frames_left != '0)) begin
        r_frames_left <= r_frames_left - L_ONE;
      end
    end
  end

  always_ff @(posedge clk_sensor_pix) begin
    if (reset_sensor) begin
      r_state            <= IDLE;
      r_done_pend        <= 1'b0;
      o_fval             <= 1'b0;
      o_lval             <= 1'b0;
      ov_pix_data        <= '0;
      o_full_frame_state <= 1'b0;
      o_frame_done       <= 1'b0;
      ov_frame_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE:    if (w_rise) r_state <= w_pass_ok ? PASS : SKIP;
        PASS:    if (w_fall) r_state <= IDLE;
        SKIP:    if (w_fall) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      // Delay the end-of-frame event one clock so it lines up with the first low o_fval.
      r_done_pend  <= w_in_pass & w_fall;
      o_frame_done <= r_done_pend;
      if (r_done_pend) ov_frame_cnt <= ov_frame_cnt + L_ONE;

      o_fval             <= r_fval_d & w_in_pass;
      o_lval             <= r_lval_d & r_fval_d & w_in_pass;
      ov_pix_data        <= (r_lval_d & r_fval_d & w_in_pass) ? r_data_d : '0;
      o_full_frame_state <= w_in_pass;
    end
  end

endmodule

// File: tb/tb_stream_ctrl_mch.sv
// Directed bench for stream_ctrl_mch: 4x12-bit channels, 4-bit frame counter.
module tb_stream_ctrl_mch;

  localparam int DW    = 12;
  localparam int CN    = 4;
  localparam int RW    = 4;
  localparam int PW    = DW * CN;
  localparam int PPL   = 4;
  localparam int LINES = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_fval = 1'b0;
  logic          i_lval = 1'b0;
  logic [PW-1:0] i_pix = '0;
  logic          se = 1'b0;
  logic          acq = 1'b0;
  logic          enc = 1'b0;
  logic [RW-1:0] frame_num = '0;

  logic          o_fval;
  logic          o_lval;
  logic [PW-1:0] ov_pix_data;
  logic          o_full_frame_state;
  logic          o_frame_done;
  logic [RW-1:0] ov_frame_cnt;

  int passed = 0;
  int total = 0;
  int fails = 0;
  int out_frames = 0;
  int done_cnt = 0;
  int lines_seen = 0;
  int exp_cnt = 0;
  int f0 = 0;
  int d0 = 0;

  logic          h0_f = 1'b0, h1_f = 1'b0, h0_l = 1'b0, h1_l = 1'b0;
  logic [PW-1:0] h0_d = '0, h1_d = '0;
  logic          prev_ofval = 1'b0, prev_olval = 1'b0, rst_prev = 1'b1;

  always #5 clk = ~clk;

  stream_ctrl_mch #(
    .DATA_WIDTH  (DW),
    .CHANNEL_NUM (CN),
    .REG_WD      (RW)
  ) dut (
    .clk_sensor_pix      (clk),
    .reset_sensor        (reset),
    .i_fval              (i_fval),
    .i_lval              (i_lval),
    .iv_pix_data         (i_pix),
    .i_stream_enable     (se),
    .i_acquisition_start (acq),
    .i_encrypt_state     (enc),
    .iv_frame_num        (frame_num),
    .o_fval              (o_fval),
    .o_lval              (o_lval),
    .ov_pix_data         (ov_pix_data),
    .o_full_frame_state  (o_full_frame_state),
    .o_frame_done        (o_frame_done),
    .ov_frame_cnt        (ov_frame_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] rnd();
    return PW'({$urandom(), $urandom()});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int vblank, input int se_line, input int rst_line);
    i_fval = 1'b1; i_lval = 1'b0; i_pix = rnd(); tick();
    for (int l = 0; l < LINES; l++) begin
      if (l == se_line) se = ~se;
      for (int p = 0; p < PPL; p++) begin
        reset  = (l == rst_line) && (p == 0);
        i_lval = 1'b1; i_pix = rnd(); tick();
      end
      reset = 1'b0; i_lval = 1'b0; i_pix = rnd(); tick();
    end
    i_fval = 1'b0;
    for (int v = 0; v < vblank; v++) begin
      i_pix = rnd(); tick();
    end
  endtask

  task automatic frames(input int n, input int vblank, input int se_line, input int rst_line);
    f0 = out_frames;
    d0 = done_cnt;
    for (int i = 0; i < n; i++) send_frame(vblank, se_line, rst_line);
  endtask

  task automatic expect_step(input string tag, input int npass);
    repeat (4) tick();
    exp_cnt += npass;
    chk({tag, "_frames"}, 64'(out_frames - f0), 64'(npass));
    chk({tag, "_done"}, 64'(done_cnt - d0), 64'(npass));
    chk({tag, "_cnt"}, 64'(ov_frame_cnt), 64'(exp_cnt % (1 << RW)));
  endtask

  // Output must be the input delayed two clocks, gated to whole passed frames.
  always @(negedge clk) begin
    if (reset) begin
    end else if (rst_prev) begin
      chk("post_rst_fval", 64'(o_fval), 64'(0));
      chk("post_rst_lval", 64'(o_lval), 64'(0));
      chk("post_rst_done", 64'(o_frame_done), 64'(0));
    end else begin
      chk("lval", 64'(o_lval), 64'(o_fval & h1_l));
      chk("fval_src", 64'(o_fval & ~h1_f), 64'(0));
      chk("pix", 64'(ov_pix_data), 64'(o_lval ? h1_d : '0));
      chk("full", 64'(o_full_frame_state), 64'(o_fval));
      chk("done", 64'(o_frame_done), 64'(prev_ofval & ~o_fval));
      if (prev_ofval & ~o_fval) chk("lines", 64'(lines_seen), 64'(LINES));
    end
    if (o_fval & ~prev_ofval) begin
      out_frames++;
      lines_seen = 0;
    end
    if (o_lval & ~prev_olval) lines_seen++;
    if (o_frame_done) done_cnt++;
    prev_ofval = o_fval;
    prev_olval = o_lval;
    rst_prev   = reset;
    h1_f = h0_f; h1_l = h0_l; h1_d = h0_d;
    h0_f = i_fval; h0_l = i_lval; h0_d = i_pix;
  end

  initial begin
    reset = 1'b1; i_fval = 1'b1; se = 1'b1; acq = 1'b1; enc = 1'b1; frame_num = '0;
    repeat (3) tick();
    chk("rst_fval", 64'(o_fval), 64'(0));
    chk("rst_lval", 64'(o_lval), 64'(0));
    chk("rst_pix", 64'(ov_pix_data), 64'(0));
    chk("rst_full", 64'(o_full_frame_state), 64'(0));
    chk("rst_done", 64'(o_frame_done), 64'(0));
    chk("rst_cnt", 64'(ov_frame_cnt), 64'(0));

    // Release reset in the middle of a frame: that frame must not appear.
    reset = 1'b0;
    f0 = out_frames;
    d0 = done_cnt;
    for (int l = 0; l < 2; l++) begin
      i_lval = 1'b1;
      for (int p = 0; p < PPL; p++) begin
        i_pix = rnd(); tick();
      end
      i_lval = 1'b0; tick();
    end
    i_fval = 1'b0;
    expect_step("rel_mid", 0);
    frames(1, 3, -1, -1);
    expect_step("first", 1);

    frames(4, 3, -1, -1);
    expect_step("cont", 4);

    frames(3, 1, -1, -1);
    expect_step("minblank", 3);

    se = 1'b0;
    frames(1, 3, -1, -1);
    expect_step("se_off", 0);
    frame_num = 4'd3; se = 1'b1; tick();
    frames(5, 3, -1, -1);
    expect_step("nshot1", 3);
    se = 1'b0; tick(); se = 1'b1; tick();
    frames(4, 3, -1, -1);
    expect_step("nshot2", 3);

    frame_num = '0; se = 1'b0; tick(); se = 1'b1; tick();
    frames(3, 3, -1, -1);
    expect_step("wrap", 3);
    chk("cnt_wrap", 64'(ov_frame_cnt), 64'(1));

    // SE toggles mid-frame: frames starting with SE=1 pass whole, others are skipped whole.
    frames(6, 3, 3, -1);
    expect_step("midtoggle", 3);

    enc = 1'b0;
    frames(2, 3, -1, -1);
    expect_step("enc_off", 0);
    enc = 1'b1;
    acq = 1'b0;
    frames(1, 3, -1, -1);
    expect_step("acq_off", 0);
    acq = 1'b1;

    // Reset in the middle of a passed frame: truncated, no done pulse, counter cleared.
    frames(1, 3, -1, 2);
    repeat (4) tick();
    chk("rstmid_started", 64'(out_frames - f0), 64'(1));
    chk("rstmid_done", 64'(done_cnt - d0), 64'(0));
    chk("rstmid_cnt", 64'(ov_frame_cnt), 64'(0));
    exp_cnt = 0;
    frames(1, 3, -1, -1);
    expect_step("after_rst", 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
